axis_byte_packer: RTL
=====================

Name: axis_byte_packer

Overview:
- Downstream consumer of the 8-bit AXI-Stream register stage.
- Packs accepted 8-bit beats into LANES-byte output words and emits them on an AXI-Stream master interface with keep and last.
- Flushes a partial word when the input beat carries Tlast_in.
- Keeps a running count of completed packets for status readout.

Parameters:
- LANES, 4, number of byte lanes per output word. Legal values are 2, 4 and 8.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- in_data  input  8  slave byte.
- T_valid_in  input  1  slave valid.
- T_ready_out  output  1  slave ready.
- Tlast_in  input  1  slave last; marks the final byte of a packet.
- out_data  output  8*LANES  master word; lane i = bits [8i+7:8i].
- T_keep_out  output  LANES  master keep; bit i set when lane i holds a valid byte.
- T_valid_out  output  1  master valid.
- T_ready_in  input  1  master ready from downstream.
- Tlast_out  output  1  master last.
- pkt_count  output  CNT_W  number of packets completed on the master side.

Behaviour:
- Reset (reset=0 at a clk edge):
  - out_data=0, T_keep_out=0, T_valid_out=0, Tlast_out=0, pkt_count=0.
  - Byte counter = 0; assembly register and assembly keep cleared.
  - A partially assembled word is discarded.
  - The reset value of any output is visible the cycle after the reset edge.
- Slave handshake:
  - A byte is accepted when T_valid_in & T_ready_out at a clk edge.
  - T_ready_out = reset & (~T_valid_out | T_ready_in), combinational.
  - T_ready_out is 0 while reset=0.
- Byte placement:
  - First byte of a word goes to lane 0 (little-endian), then lane 1, and so on.
  - Byte counter runs 0..LANES-1.
- Word completion: when the accepted byte fills lane LANES-1, or carries Tlast_in=1:
  - out_data gets the assembled lanes plus the incoming byte; unused lanes are 0.
  - T_keep_out gets a contiguous low-order ones mask (e.g. 3 bytes -> 4'b0111).
  - Tlast_out gets Tlast_in.
  - T_valid_out is set to 1.
  - Byte counter is set to 0; assembly keep is cleared.
  - Latency: 1 cycle from the accepting edge to T_valid_out=1.
- Non-completing accepted byte: stored in its lane, assembly keep bit set, byte counter increments. Outputs are unchanged.
- Master handshake:
  - A word transfers when T_valid_out & T_ready_in.
  - out_data, T_keep_out and Tlast_out hold stable while T_valid_out=1 and T_ready_in=0.
  - After a transfer with no new completion in the same cycle: T_valid_out=0; out_data and T_keep_out hold their last value.
  - Simultaneous transfer and new completion: the output register reloads and T_valid_out stays 1, sustaining 1 byte/cycle with no bubble.
- Backpressure:
  - With T_valid_out=1 and T_ready_in=0, T_ready_out=0 and no bytes are accepted.
  - Partial assembly stalls intact.
- Tlast_in on the first byte of a word gives a single-lane word (keep = 1).
- Tlast_in exactly on the lane LANES-1 byte gives a full keep with Tlast_out=1. No extra empty word is produced.
- pkt_count increments by 1 on each master transfer with Tlast_out=1 and wraps at 2^CNT_W-1 -> 0.
- T_valid_in=0 and in_data changes are ignored; in_data is sampled only on an accept.
- No combinational path from in_data to out_data.

Test Plan:
1. Reset low 2 cycles, then high, T_ready_in=1; send 12,22,33,44 with Tlast_in=0. Required: one cycle after the 44 accept, out_data=0x44332212, T_keep_out=4'hF, Tlast_out=0, pkt_count=0.
2. Send 55,66,77 with Tlast_in=1 on 77. Required: out_data=0x00776655, keep=4'h7, Tlast_out=1; pkt_count=1 after the transfer.
3. Stream 8 bytes 0x01..0x08 back-to-back with T_ready_in=1 and Tlast_in on 0x08. Required: T_ready_out stays 1 throughout; words 0x04030201 (keep F, last 0) then 0x08070605 (keep F, last 1); pkt_count=1.
4. Hold T_ready_in=0 after word 0xAA998877 is valid. Required: T_ready_out=0, word stable for 5 cycles, no input consumed. Release: word transfers once and T_ready_out returns to 1.
5. Send 0xBB, 0xCC without last, then pull reset low for 1 cycle. Required: T_valid_out=0, pkt_count=0. Next bytes 0xDD (last) give out_data=0x000000DD, keep=4'h1.
6. Force pkt_count to wrap: with CNT_W=2, send 5 single-byte packets. Required: pkt_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs an 8-bit AXI-Stream into LANES-byte words with
// keep/last. A partial word is flushed when the input beat carries last.
// It also counts the packets completed on the master side.
module axis_byte_packer #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 T_valid_in,
    output logic                 T_ready_out,
    input  logic                 Tlast_in,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     T_keep_out,
    output logic                 T_valid_out,
    input  logic                 T_ready_in,
    output logic                 Tlast_out,
    output logic [CNT_W-1:0]     pkt_count
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IW-1:0]           cnt_q, cnt_d;
    logic [LANES-1:0][7:0]   asm_q, asm_d;
    logic [LANES-1:0]        akeep_q, akeep_d;
    logic [LANES-1:0][7:0]   word_q, word_d;
    logic [LANES-1:0]        keep_q, keep_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;
    logic [CNT_W-1:0]        pkt_q, pkt_d;

    logic                    accept, fill, xfer;
    logic [LANES-1:0]        lane_oh;
    logic [LANES-1:0][7:0]   new_word;

    // Accept a byte whenever the output register is free or draining this cycle.
    assign T_ready_out = reset & (~vld_q | T_ready_in);
    assign accept      = T_valid_in & T_ready_out;
    assign fill        = accept & ((cnt_q == IW'(LANES - 1)) | Tlast_in);
    assign xfer        = vld_q & T_ready_in;
    assign lane_oh     = LANES'(1) << cnt_q;

    assign out_data    = word_q;
    assign T_keep_out  = keep_q;
    assign T_valid_out = vld_q;
    assign Tlast_out   = last_q;
    assign pkt_count   = pkt_q;

    // Completed word: only lanes already assembled survive, stale lanes read 0.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            new_word[i] = akeep_q[i] ? asm_q[i] : 8'h00;
        new_word[cnt_q] = in_data;
    end

    // Next-state: assembly, output register reload and packet counting.
    always_comb begin
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        akeep_d = akeep_q;
        word_d  = word_q;
        keep_d  = keep_q;
        vld_d   = vld_q;
        last_d  = last_q;
        pkt_d   = pkt_q + CNT_W'(xfer & last_q);

        // A transfer frees the output; a completion in the same cycle refills it.
        if (xfer)
            vld_d = 1'b0;

        if (accept) begin
            if (fill) begin
                word_d  = new_word;
                keep_d  = akeep_q | lane_oh;   // lanes fill from 0, so this is contiguous
                last_d  = Tlast_in;
                vld_d   = 1'b1;
                cnt_d   = '0;
                akeep_d = '0;
            end else begin
                asm_d[cnt_q] = in_data;
                akeep_d      = akeep_q | lane_oh;
                cnt_d        = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            akeep_q <= '0;
            word_q  <= '0;
            keep_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            akeep_q <= akeep_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule
